// File: rtl/decode_pkg.sv
// Shared RISC-V decode constants: major opcodes, out_op bit positions and immediate formats.
package decode_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ARITH   = 7'b0110011;
  localparam logic [6:0] OPC_ARITHI  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_ARITHW  = 7'b0111011;
  localparam logic [6:0] OPC_ARITHIW = 7'b0011011;

  localparam int OP_LUI     = 0;
  localparam int OP_AUIPC   = 1;
  localparam int OP_JAL     = 2;
  localparam int OP_JALR    = 3;
  localparam int OP_BRANCH  = 4;
  localparam int OP_LOAD    = 5;
  localparam int OP_STORE   = 6;
  localparam int OP_ARITH   = 7;
  localparam int OP_ARITHI  = 8;
  localparam int OP_SYSTEM  = 9;
  localparam int OP_ARITHW  = 10;
  localparam int OP_ARITHIW = 11;
  localparam int OP_W       = 12;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic logic [7:0] onehot3(input logic [2:0] v);
    onehot3 = 8'b1 << v;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: op class, funct flags, register fields,
// sign-extended immediate and legality under the XLEN / M-extension configuration.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic [31:0]     instr_i,
  output logic [OP_W-1:0] op_o,
  output logic [7:0]      funct3_o,
  output logic            f7_alt_o,
  output logic            f7_m_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  localparam bit RV32 = (XLEN == 32);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_ok;
  logic            shamt_hi_ok;
  logic            is_shift;
  logic            bad;
  logic [OP_W-1:0] op_raw;
  imm_type_e       imm_type;
  logic [31:0]     imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign funct3_o = onehot3(funct3);
  assign f7_alt_o = (funct7 == 7'b0100000);
  assign f7_m_o   = (funct7 == 7'b0000001);
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign rd_o     = instr_i[11:7];

  always_comb begin
    f7_ok = (funct7 == 7'b0000000)
         || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
         || (funct7 == 7'b0000001 && HAS_M != 0);
    shamt_hi_ok = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
    is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
    op_raw      = '0;
    imm_type    = IMM_NONE;
    bad         = 1'b0;
    case (opcode)
      OPC_LUI:    begin op_raw[OP_LUI]   = 1'b1; imm_type = IMM_U; end
      OPC_AUIPC:  begin op_raw[OP_AUIPC] = 1'b1; imm_type = IMM_U; end
      OPC_JAL:    begin op_raw[OP_JAL]   = 1'b1; imm_type = IMM_J; end
      OPC_JALR: begin
        op_raw[OP_JALR] = 1'b1;
        imm_type        = IMM_I;
        bad             = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        op_raw[OP_BRANCH] = 1'b1;
        imm_type          = IMM_B;
        bad               = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        op_raw[OP_LOAD] = 1'b1;
        imm_type        = IMM_I;
        bad             = (funct3 == 3'b111)
                       || (RV32 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OPC_STORE: begin
        op_raw[OP_STORE] = 1'b1;
        imm_type         = IMM_S;
        bad              = funct3[2] || (RV32 && funct3[1] && funct3[0]);
      end
      OPC_ARITH: begin
        op_raw[OP_ARITH] = 1'b1;
        bad              = !f7_ok;
      end
      OPC_ARITHI: begin
        op_raw[OP_ARITHI] = 1'b1;
        imm_type          = IMM_I;
        // RV64 uses instr[25] as shamt[5]; RV32 has only a 5-bit shamt
        bad               = is_shift && (!shamt_hi_ok || (RV32 && instr_i[25]));
      end
      OPC_SYSTEM: op_raw[OP_SYSTEM] = 1'b1;
      OPC_ARITHW: begin
        op_raw[OP_ARITHW] = 1'b1;
        bad               = RV32 || !f7_ok;
      end
      OPC_ARITHIW: begin
        op_raw[OP_ARITHIW] = 1'b1;
        imm_type           = IMM_I;
        bad                = RV32
                          || (is_shift && !(funct7 == 7'b0000000 || funct7 == 7'b0100000));
      end
      default: bad = 1'b1;
    endcase
    if (opcode[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      op_raw   = '0;
      imm_type = IMM_NONE;
    end
  end

  always_comb begin
    case (imm_type)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign op_o      = op_raw;
  assign illegal_o = bad;
  assign imm_o     = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// main entry plus optional skid entry so in_ready can come straight from a flop.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0,
  parameter int SKID  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_op,
  output logic [7:0]      out_funct3,
  output logic            out_f7_alt,
  output logic            out_f7_m,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  localparam int PW = 2 * XLEN + OP_W + 8 + 2 + 15 + 1;

  logic [OP_W-1:0] dec_op;
  logic [7:0]      dec_f3;
  logic            dec_alt;
  logic            dec_m;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic [PW-1:0]   dec_pl;

  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic            valid_q, valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            drain;

  decode_comb #(.XLEN(XLEN), .HAS_M(HAS_M)) u_decode_comb (
    .instr_i   (in_instr),
    .op_o      (dec_op),
    .funct3_o  (dec_f3),
    .f7_alt_o  (dec_alt),
    .f7_m_o    (dec_m),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .rd_o      (dec_rd),
    .imm_o     (dec_imm),
    .illegal_o (dec_ill)
  );

  assign dec_pl = {in_pc, dec_imm, dec_op, dec_f3, dec_alt, dec_m,
                   dec_rs1, dec_rs2, dec_rd, dec_ill};

  assign in_ready = (SKID != 0) ? in_ready_q : (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      // in_ready is low while the skid entry is full, so no accept can coincide here
      if (drain && skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept && (!valid_q || drain)) begin
        main_d  = dec_pl;
        valid_d = 1'b1;
      end else if (accept) begin
        skid_d       = dec_pl;
        skid_valid_d = 1'b1;
      end else if (drain) begin
        valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        main_d  = dec_pl;
        valid_d = 1'b1;
      end else if (drain) begin
        valid_d = 1'b0;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = valid_q;
  assign {out_pc, out_imm, out_op, out_funct3, out_f7_alt, out_f7_m,
          out_rs1, out_rs2, out_rd, out_illegal} = main_q;

endmodule
